// File: rtl/sa_result_collect.sv
// sa_result_collect: gathers the skewed drain stream of an X_ROW x Y_COL
// systolic array into a row-major result matrix and hands it off with a
// valid/ready pair.
module sa_result_collect #(
    parameter int unsigned ACC_WIDTH = 20,
    parameter int unsigned X_ROW     = 3,
    parameter int unsigned Y_COL     = 3
) (
    input  logic                                     sys_clk,
    input  logic                                     sys_rst,
    input  logic                                     start,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic signed [X_ROW*ACC_WIDTH-1:0]        in_data,
    output logic signed [ACC_WIDTH*X_ROW*Y_COL-1:0]  z,
    output logic                                     z_valid,
    input  logic                                     z_ready,
    output logic                                     busy
);

    localparam int unsigned T_BEATS = X_ROW + Y_COL - 1;
    localparam int unsigned CNT_W   = $clog2(T_BEATS + 1);
    localparam int unsigned IN_W    = X_ROW * ACC_WIDTH;
    localparam int unsigned Z_W     = ACC_WIDTH * X_ROW * Y_COL;
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   t;
    logic               beat_acc;
    logic [ACC_WIDTH-1:0] lane [X_ROW];

    // in_ready is a pure decode of the state register, so in_data never
    // reaches an output without passing through a flop.
    assign in_ready = (state == COLLECT);
    assign beat_acc = in_valid && (state == COLLECT);

    // Split the drain bus into lanes; lane 0 sits at the MSB end.
    always_comb begin
        for (int s = 0; s < X_ROW; s++) begin
            lane[s] = in_data[(IN_W-1) - s*ACC_WIDTH -: ACC_WIDTH];
        end
    end

    // Control FSM: beat counter, handshake flags and busy indication.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            t       <= '0;
            z_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        t     <= '0;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        t <= t + CNT_W'(1);
                        if (t == T_LAST) begin
                            state   <= DONE;
                            z_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A start arriving alongside z_ready is deliberately dropped.
                    if (z_ready) begin
                        state   <= IDLE;
                        z_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    t       <= '0;
                    z_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Result matrix: cleared on an accepted start, then on beat t lane s
    // lands in element (s, t-s) when that column exists; other lanes are
    // skew padding and are dropped.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            z <= '0;
        end else if ((state == IDLE) && start) begin
            z <= '0;
        end else if (beat_acc) begin
            for (int s = 0; s < X_ROW; s++) begin
                for (int j = 0; j < Y_COL; j++) begin
                    if (t == CNT_W'(s + j)) begin
                        z[(Z_W-1) - (s*Y_COL + j)*ACC_WIDTH -: ACC_WIDTH] <= lane[s];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_result_collect.sv
// Self-checking bench for sa_result_collect: a default 3x3 instance and a
// 2x4 instance, driven from random and directed matrices.
module tb_sa_result_collect;

    localparam int W  = 20;
    localparam int AX = 3;
    localparam int AY = 3;
    localparam int BX = 2;
    localparam int BY = 4;

    typedef logic [W-1:0] mat_t [4][4];
    typedef int stall_t [5];

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // instance A (3x3)
    logic                  a_rst, a_start, a_in_valid, a_z_ready;
    logic                  a_in_ready, a_z_valid, a_busy;
    logic [AX*W-1:0]       a_in_data;
    logic [W*AX*AY-1:0]    a_z;

    // instance B (2x4)
    logic                  b_rst, b_start, b_in_valid, b_z_ready;
    logic                  b_in_ready, b_z_valid, b_busy;
    logic [BX*W-1:0]       b_in_data;
    logic [W*BX*BY-1:0]    b_z;

    sa_result_collect #(.ACC_WIDTH(W), .X_ROW(AX), .Y_COL(AY)) u_dut_a (
        .sys_clk (sys_clk),
        .sys_rst (a_rst),
        .start   (a_start),
        .in_valid(a_in_valid),
        .in_ready(a_in_ready),
        .in_data (a_in_data),
        .z       (a_z),
        .z_valid (a_z_valid),
        .z_ready (a_z_ready),
        .busy    (a_busy)
    );

    sa_result_collect #(.ACC_WIDTH(W), .X_ROW(BX), .Y_COL(BY)) u_dut_b (
        .sys_clk (sys_clk),
        .sys_rst (b_rst),
        .start   (b_start),
        .in_valid(b_in_valid),
        .in_ready(b_in_ready),
        .in_data (b_in_data),
        .z       (b_z),
        .z_valid (b_z_valid),
        .z_ready (b_z_ready),
        .busy    (b_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected z: the matrix itself, row-major, element (0,0) at the MSB end.
    function automatic logic [255:0] pack_z(input mat_t m, input int nx, input int ny);
        logic [255:0] r;
        int total;
        r = '0;
        total = W * nx * ny;
        for (int i = 0; i < nx; i++)
            for (int j = 0; j < ny; j++)
                r[(total-1) - (i*ny + j)*W -: W] = m[i][j];
        return r;
    endfunction

    // Drain beat t of a systolic array holding m: row s emits column t-s.
    function automatic logic [79:0] make_beat(input mat_t m, input int nx, input int ny,
                                              input int t, input bit junk_ones);
        logic [79:0] r;
        r = '0;
        for (int s = 0; s < nx; s++) begin
            if (t - s >= 0 && t - s < ny)
                r[(nx*W-1) - s*W -: W] = m[s][t-s];
            else
                r[(nx*W-1) - s*W -: W] = junk_ones ? 20'hFFFFF : W'($urandom);
        end
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = W'($urandom);
        return m;
    endfunction

    // One full collection on instance A with configurable stalls and DONE hold.
    task automatic a_collect(input mat_t m, input bit junk_ones, input stall_t st,
                             input int hold, input bit junk_start);
        logic [255:0] ez;
        ez = pack_z(m, AX, AY);
        @(negedge sys_clk);
        check("a_idle_in_ready", 256'(a_in_ready), 256'(0));
        check("a_idle_busy", 256'(a_busy), 256'(0));
        a_start    = 1'b1;
        a_in_valid = 1'b0;
        @(negedge sys_clk);
        a_start = 1'b0;
        check("a_start_busy", 256'(a_busy), 256'(1));
        check("a_start_in_ready", 256'(a_in_ready), 256'(1));
        check("a_start_z_clear", 256'(a_z), 256'(0));
        for (int t = 0; t < AX + AY - 1; t++) begin
            for (int k = 0; k < st[t]; k++) begin
                a_in_valid = 1'b0;
                a_in_data  = AX*W'($urandom);
                a_start    = junk_start & 1'($urandom);
                @(negedge sys_clk);
                check("a_stall_z_valid", 256'(a_z_valid), 256'(0));
                check("a_stall_in_ready", 256'(a_in_ready), 256'(1));
            end
            a_in_valid = 1'b1;
            a_in_data  = (AX*W)'(make_beat(m, AX, AY, t, junk_ones));
            a_start    = junk_start & 1'($urandom);
            @(negedge sys_clk);
            if (t < AX + AY - 2) begin
                check("a_collect_z_valid", 256'(a_z_valid), 256'(0));
            end else begin
                check("a_done_z_valid", 256'(a_z_valid), 256'(1));
                check("a_done_z", 256'(a_z), ez);
                check("a_done_busy", 256'(a_busy), 256'(1));
                check("a_done_in_ready", 256'(a_in_ready), 256'(0));
            end
        end
        a_in_valid = 1'b0;
        a_start    = 1'b0;
        for (int h = 0; h < hold; h++) begin
            a_z_ready  = 1'b0;
            a_start    = junk_start & 1'($urandom);
            a_in_valid = 1'($urandom);
            a_in_data  = AX*W'($urandom);
            @(negedge sys_clk);
            check("a_hold_z_valid", 256'(a_z_valid), 256'(1));
            check("a_hold_z", 256'(a_z), ez);
            check("a_hold_busy", 256'(a_busy), 256'(1));
        end
        a_in_valid = 1'b0;
        a_z_ready  = 1'b1;
        a_start    = 1'($urandom);
        @(negedge sys_clk);
        a_z_ready = 1'b0;
        a_start   = 1'b0;
        check("a_release_z_valid", 256'(a_z_valid), 256'(0));
        check("a_release_busy", 256'(a_busy), 256'(0));
        check("a_release_in_ready", 256'(a_in_ready), 256'(0));
        check("a_release_z_kept", 256'(a_z), ez);
        @(negedge sys_clk);
        check("a_idle_busy_after", 256'(a_busy), 256'(0));
        check("a_idle_z_kept", 256'(a_z), ez);
    endtask

    // Reset in the middle of a collection on instance A.
    task automatic a_reset_mid(input mat_t m);
        @(negedge sys_clk);
        a_start = 1'b1;
        @(negedge sys_clk);
        a_start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            a_in_valid = 1'b1;
            a_in_data  = (AX*W)'(make_beat(m, AX, AY, t, 1'b0));
            @(negedge sys_clk);
        end
        a_rst = 1'b1;
        #1;
        check("a_rst_z", 256'(a_z), 256'(0));
        check("a_rst_z_valid", 256'(a_z_valid), 256'(0));
        check("a_rst_busy", 256'(a_busy), 256'(0));
        check("a_rst_in_ready", 256'(a_in_ready), 256'(0));
        @(negedge sys_clk);
        a_rst = 1'b0;
        for (int t = 3; t < 9; t++) begin
            a_in_valid = 1'b1;
            a_in_data  = (AX*W)'(make_beat(m, AX, AY, t % 5, 1'b0));
            @(negedge sys_clk);
            check("a_post_rst_in_ready", 256'(a_in_ready), 256'(0));
            check("a_post_rst_z", 256'(a_z), 256'(0));
            check("a_post_rst_busy", 256'(a_busy), 256'(0));
        end
        a_in_valid = 1'b0;
    endtask

    // One back-to-back collection on instance B.
    task automatic b_collect(input mat_t m);
        logic [255:0] ez;
        ez = pack_z(m, BX, BY);
        @(negedge sys_clk);
        b_start = 1'b1;
        @(negedge sys_clk);
        b_start = 1'b0;
        check("b_start_busy", 256'(b_busy), 256'(1));
        for (int t = 0; t < BX + BY - 1; t++) begin
            b_in_valid = 1'b1;
            b_in_data  = (BX*W)'(make_beat(m, BX, BY, t, 1'b0));
            @(negedge sys_clk);
            check("b_z_valid", 256'(b_z_valid), (t == BX + BY - 2) ? 256'(1) : 256'(0));
        end
        b_in_valid = 1'b0;
        check("b_done_z", 256'(b_z), ez);
        b_z_ready = 1'b1;
        @(negedge sys_clk);
        b_z_ready = 1'b0;
        check("b_release_z_valid", 256'(b_z_valid), 256'(0));
        check("b_release_z_kept", 256'(b_z), ez);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mat_t   m;
        stall_t st;
        a_rst = 1'b1; a_start = 1'b0; a_in_valid = 1'b0; a_z_ready = 1'b0; a_in_data = '0;
        b_rst = 1'b1; b_start = 1'b0; b_in_valid = 1'b0; b_z_ready = 1'b0; b_in_data = '0;
        #1;
        check("a_reset_z", 256'(a_z), 256'(0));
        check("a_reset_z_valid", 256'(a_z_valid), 256'(0));
        check("a_reset_busy", 256'(a_busy), 256'(0));
        check("a_reset_in_ready", 256'(a_in_ready), 256'(0));
        @(negedge sys_clk);
        @(negedge sys_clk);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // directed: z(i,j)=16*i+j, padding lanes all ones
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = W'(16*i + j);
        st = '{0, 0, 0, 0, 0};
        a_collect(m, 1'b1, st, 0, 1'b0);

        // same data with two 2-cycle stalls after beats 1 and 3
        st = '{0, 0, 2, 0, 2};
        a_collect(m, 1'b1, st, 0, 1'b0);

        // signed extremes pass bit-exact
        m = rand_mat();
        m[0][0] = 20'hFFFFF;
        m[1][2] = 20'h80000;
        m[2][1] = 20'hFFFFF;
        m[2][2] = 20'h80000;
        st = '{0, 0, 0, 0, 0};
        a_collect(m, 1'b0, st, 1, 1'b0);

        // long DONE hold with stray start pulses throughout
        m = rand_mat();
        st = '{1, 0, 1, 0, 0};
        a_collect(m, 1'b0, st, 4, 1'b1);

        // randomized collections
        for (int n = 0; n < 8; n++) begin
            m = rand_mat();
            for (int t = 0; t < 5; t++) st[t] = int'($urandom_range(2));
            a_collect(m, 1'($urandom), st, int'($urandom_range(4)), 1'b1);
        end

        // reset mid-collection, then a clean collection afterwards
        m = rand_mat();
        a_reset_mid(m);
        m = rand_mat();
        st = '{0, 0, 0, 0, 0};
        a_collect(m, 1'b0, st, 0, 1'b0);

        // 2x4 geometry
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = W'(16*i + j);
        b_collect(m);
        for (int n = 0; n < 3; n++) b_collect(rand_mat());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
